// File: rtl/servo_pwm_gen_if.sv
// servo_pwm_gen_if
//   Command/status bundle between the steering stage and the servo PWM
//   generator.
//   master : drives enable and pulse_width; observes the PWM status.
//   slave  : the PWM generator itself.
//   Signals:
//     enable       run request, level-sensitive
//     pulse_width  commanded pulse width in microseconds (unsigned, 11 bits)
//     servo_out    registered servo PWM pin
//     frame_start  one-cycle pulse on the first cycle of every frame
//     pw_active    pulse width used for the current frame, microseconds
interface servo_pwm_gen_if;
   logic        enable;
   logic [10:0] pulse_width;
   logic        servo_out;
   logic        frame_start;
   logic [10:0] pw_active;

   modport master (
      output enable,
      output pulse_width,
      input  servo_out,
      input  frame_start,
      input  pw_active
   );

   modport slave (
      input  enable,
      input  pulse_width,
      output servo_out,
      output frame_start,
      output pw_active
   );
endinterface

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Hobby-servo PWM generator. Each frame is FRAME_US microseconds long and
//   starts with one high pulse whose width is pw_active microseconds. The
//   pulse-width command is only looked at on frame boundaries. At that point
//   it is clamped to PW_MIN..PW_MAX, and the change from the previous frame
//   is limited to SLEW_US.
//   Ports:
//     clk  system clock (CLK_HZ, an integer multiple of 1 MHz)
//     rst  synchronous, active-high reset
//     bus  servo_pwm_gen_if.slave (enable, pulse_width in; servo_out,
//          frame_start, pw_active out; all outputs registered)
module servo_pwm_gen #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int FRAME_US   = 20000,
   parameter int PW_MIN     = 1000,
   parameter int PW_MAX     = 2000,
   parameter int PW_NEUTRAL = 1500,
   parameter int SLEW_US    = 10
) (
   input  logic             clk,
   input  logic             rst,
   servo_pwm_gen_if.slave   bus
);

   localparam int DIV   = CLK_HZ / 1_000_000;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int US_W  = $clog2(FRAME_US);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
   localparam logic [US_W-1:0]  US_LAST   = US_W'(FRAME_US - 1);
   localparam logic [10:0]      PW_MIN_C  = 11'(PW_MIN);
   localparam logic [10:0]      PW_MAX_C  = 11'(PW_MAX);
   localparam logic [10:0]      PW_NEU_C  = 11'(PW_NEUTRAL);
   localparam logic [10:0]      SLEW_11   = 11'(SLEW_US);
   localparam logic [12:0]      SLEW_13   = 13'(SLEW_US);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [US_W-1:0]  us_cnt_q, us_cnt_d;
   logic [10:0]      pw_active_q, pw_active_d;
   logic             servo_q, servo_d;
   logic             frame_start_q, frame_start_d;

   logic             tick;
   logic             boundary;
   logic [10:0]      target;
   logic [10:0]      pw_slewed;

   // Clamp the command into the legal servo range.
   always_comb begin
      target = bus.pulse_width;
      if (bus.pulse_width < PW_MIN_C) begin
         target = PW_MIN_C;
      end else if (bus.pulse_width > PW_MAX_C) begin
         target = PW_MAX_C;
      end
   end

   // Slew limiting. The comparisons are done in 13 bits so that
   // pw_active + SLEW_US cannot wrap. The selected results cannot overflow
   // 11 bits: a step up only happens when it stays below target, and a step
   // down only happens when pw_active exceeds target + SLEW_US.
   always_comb begin
      pw_slewed = target;
      if ({2'b00, target} > ({2'b00, pw_active_q} + SLEW_13)) begin
         pw_slewed = pw_active_q + SLEW_11;
      end else if (({2'b00, target} + SLEW_13) < {2'b00, pw_active_q}) begin
         pw_slewed = pw_active_q - SLEW_11;
      end
   end

   // Next-state logic for the counters, the state and the output flops.
   always_comb begin
      tick     = (pre_q == PRE_LAST);
      boundary = ((state_q == IDLE) && bus.enable) ||
                 ((state_q == RUN) && tick && (us_cnt_q == US_LAST));

      state_d       = state_q;
      pre_d         = pre_q;
      us_cnt_d      = us_cnt_q;
      pw_active_d   = pw_active_q;
      frame_start_d = 1'b0;

      if (boundary) begin
         pre_d    = '0;
         us_cnt_d = '0;
         if (bus.enable) begin
            state_d       = RUN;
            pw_active_d   = pw_slewed;
            frame_start_d = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end else if (state_q == RUN) begin
         if (tick) begin
            pre_d    = '0;
            us_cnt_d = us_cnt_q + 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end

      // The pin is computed from the next-state values. The registered
      // output is then exactly aligned with state/us_cnt/pw_active.
      servo_d = (state_d == RUN) && (32'(us_cnt_d) < 32'(pw_active_d));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pre_q         <= '0;
         us_cnt_q      <= '0;
         pw_active_q   <= PW_NEU_C;
         servo_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pre_q         <= pre_d;
         us_cnt_q      <= us_cnt_d;
         pw_active_q   <= pw_active_d;
         servo_q       <= servo_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.servo_out   = servo_q;
   assign bus.frame_start = frame_start_q;
   assign bus.pw_active   = pw_active_q;

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Servo PWM generator directly downstream of the proximity-checked steering stage. It consumes the checked pulse-width command (microseconds, 1500 = neutral) and produces the standard hobby-servo frame: one high pulse per 20 ms frame. The command is sampled only at frame boundaries, clamped to the servo's legal range, and slew-limited so that no frame changes the pulse by more than a fixed step. It drives the Basys3 servo output pin.

## Interface
- CLK_HZ, 100_000_000: clk frequency; must be an integer multiple of 1_000_000.
- FRAME_US, 20000: frame period in µs; must be > PW_MAX.
- PW_MIN, 1000: minimum pulse width, µs.
- PW_MAX, 2000: maximum pulse width, µs.
- PW_NEUTRAL, 1500: pulse width after reset, µs.
- SLEW_US, 10: maximum pulse-width change per frame, µs; must be ≥ 1.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  run request; level-sensitive.
- pulse_width  in  11  commanded pulse width, µs, unsigned.
- servo_out  out  1  servo PWM output, registered.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- pw_active  out  11  pulse width in use for the current frame, µs.

## Operation
- Prescaler pre counts 0..CLK_HZ/1e6−1; a µs tick occurs on the cycle where pre is at its terminal value.
- µs counter us_cnt counts 0..FRAME_US−1 and advances on each tick.
- States:
  - IDLE: pre and us_cnt held at 0; servo_out = 0.
  - RUN: counters free-run.
- Frame boundary event occurs on either of these edges:
  - IDLE with enable = 1;
  - RUN with a tick while us_cnt = FRAME_US−1.
- At a frame boundary:
  - if enable = 1: next state RUN; pre and us_cnt set to 0; pw_active updated as below; frame_start = 1 in the following cycle.
  - if enable = 0 (RUN only): next state IDLE; pw_active unchanged; no frame_start.
- pw_active update, computed in ≥12 bits with no overflow:
  - target = clamp(pulse_width, PW_MIN, PW_MAX).
  - If target > pw_active + SLEW_US: pw_active + SLEW_US.
  - Else if target + SLEW_US < pw_active: pw_active − SLEW_US.
  - Else: target.
- pw_active is constant for the whole frame. Changes to pulse_width mid-frame affect only the next frame.
- servo_out = 1 exactly in cycles where state = RUN and us_cnt < pw_active. It is produced from a flop and is aligned with those register values; no combinational glitches reach the pin.
- enable deasserted mid-frame: the current frame, including its pulse, completes in full. IDLE is entered at the boundary, so no truncated pulse is produced.
- pw_active is retained through IDLE. Re-enable slews from the retained value.

## Timing
- Reset values: servo_out 0, frame_start 0, pw_active PW_NEUTRAL, state IDLE, pre 0, us_cnt 0.
- rst asserted at any time, including mid-pulse: all outputs take their reset values on the next edge.
- enable rising in IDLE: frame_start and servo_out go high on the cycle after enable is first sampled high (1-cycle latency).
- Pulse high time = pw_active × CLK_HZ/1e6 cycles exactly.
- Frame period = FRAME_US × CLK_HZ/1e6 cycles exactly. Default: 2,000,000 cycles, with 150,000 high at neutral.
- frame_start and the rising edge of servo_out occur in the same cycle.
- Maximum settle from any pw_active to any target: ceil(|Δ| / SLEW_US) frames.

## Test plan
Benches may override CLK_HZ = 2_000_000 and FRAME_US = 3000 for speed; the values below use those overrides (2 cycles/µs, 6000 cycles/frame).
- Reset: rst held 3 cycles, then enable = 0 -> servo_out 0, frame_start 0, pw_active 1500, indefinitely.
- Steady neutral: pulse_width 1500, enable 1 -> frame_start every 6000 cycles; servo_out high exactly 3000 cycles from each frame_start; first frame_start on the cycle after enable is sampled.
- Slew: from pw_active 1500, pulse_width stepped to 2000 -> pw_active 1510, 1520, … reaching 2000 at frame 50 and holding. Step back to 1995 -> 1995 next frame (|Δ| ≤ 10).
- Clamp: pulse_width 0 -> pw_active decreases 10 per frame to 1000 and holds. pulse_width 2047 -> rises to 2000 and holds; never outside 1000..2000.
- Mid-frame command change: pulse_width changed 1500→1700 at us_cnt 200 -> current frame high time still 3000 cycles; next frame 1510 µs (3020 cycles).
- Enable drop and reset:
  - enable deasserted at us_cnt 700 with pw_active 1500 -> pulse still ends at us_cnt 1500; frame runs to 3000; no further frame_start; servo_out stays 0.
  - rst asserted at us_cnt 700 instead -> servo_out 0 on the next cycle; pw_active 1500.
